hazard_unit: RTL and testbench

- Pipeline control block for the 5-stage MIPS core.
- Consumes the register tags and control bits that the decode/execute boundary register hands to EX, plus the EX/MEM/WB write tags and the data-memory handshake.
- Drives the flush/stall inputs of the pipeline registers (including flushE on the ID/EX register) and the EX forwarding selects.
- Owns a small FSM that freezes the pipeline during data-memory wait states and a timeout watchdog on those waits.

---
 rtl/hazard_unit.sv | 193 +++++++++++++++++++
 tb/tb_hazard_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline.
// It produces the stall and flush controls for the pipeline registers and the EX
// forwarding selects. It also runs a small FSM that freezes the pipeline while data
// memory is in a wait state, with a watchdog that abandons waits that run too long.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   rsD, rtD                 source tags of the instruction in ID
//   rsE, rtE                 source tags of the instruction in EX
//   writeReg{E,M,W}          destination tags per stage
//   Regfile_we{E,M,W}        register write enables per stage
//   regSrc_muxE              write-back source of the EX instruction (load detection)
//   pc_srcD                  branch/jump taken in ID
//   dmem_req, dmem_ready     data-memory handshake of the MEM stage
//   stall{F,D,E,M}           hold PC, IF/ID, ID/EX, EX/MEM
//   flush{D,E}               bubble IF/ID, ID/EX
//   forward{A,B}E            00 = regfile, 01 = WB, 10 = MEM
//   mem_err                  sticky watchdog flag
//
// Optional build macro HAZARD_PERF_EN adds saturating counters perf_mem_stall,
// perf_lu_stall and perf_flush. Without it the ports and counters are absent.
module hazard_unit #(
  parameter logic [1:0] REGSRC_MEM  = 2'b01,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       Regfile_weE,
  input  logic       Regfile_weM,
  input  logic       Regfile_weW,
  input  logic [1:0] regSrc_muxE,
  input  logic       pc_srcD,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic freeze;
  logic lu_hit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic. wait_cnt counts wait cycles of the current access, so it is
  // already 1 on the first MEM_WAIT cycle. When it reaches the timeout, the access
  // is abandoned and the flag latches until reset.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= TIMEOUT_C) begin
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign freeze = ((state_q == RUN) && dmem_req && !dmem_ready) ||
                  ((state_q == MEM_WAIT) && !dmem_ready && (wait_cnt_q < TIMEOUT_C));

  assign lu_hit = Regfile_weE && (regSrc_muxE == REGSRC_MEM) && (writeRegE != 5'd0) &&
                  ((writeRegE == rsD) || (writeRegE == rtD));

  // Output logic. Priority: memory freeze, then load-use, then branch flush.
  // A load-use hit suppresses flushD, so a branch that depends on the load
  // resolves again next cycle with correct operands. Reset forces all controls low.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (rst) begin
      if (freeze) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (lu_hit) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else if (pc_srcD) begin
        flushD = 1'b1;
      end
    end
  end

  // Forwarding is independent of the FSM. MEM is newer than WB and wins.
  // $0 is never forwarded.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rst) begin
      if (Regfile_weM && (writeRegM != 5'd0) && (writeRegM == rsE))
        forwardAE = 2'b10;
      else if (Regfile_weW && (writeRegW != 5'd0) && (writeRegW == rsE))
        forwardAE = 2'b01;

      if (Regfile_weM && (writeRegM != 5'd0) && (writeRegM == rtE))
        forwardBE = 2'b10;
      else if (Regfile_weW && (writeRegW != 5'd0) && (writeRegW == rtE))
        forwardBE = 2'b01;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_mem_q, perf_lu_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mem_q   <= '0;
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      if (freeze && (perf_mem_q != 32'hFFFF_FFFF))
        perf_mem_q <= perf_mem_q + 32'd1;
      if (lu_hit && !freeze && (perf_lu_q != 32'hFFFF_FFFF))
        perf_lu_q <= perf_lu_q + 32'd1;
      if (flushD && (perf_flush_q != 32'hFFFF_FFFF))
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_mem_stall = perf_mem_q;
  assign perf_lu_stall  = perf_lu_q;
  assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       Regfile_weE, Regfile_weM, Regfile_weW;
  logic [1:0] regSrc_muxE;
  logic       pc_srcD, dmem_req, dmem_ready;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, mem_err;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_mem_stall, perf_lu_stall, perf_flush;
`endif

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM), .Regfile_weW(Regfile_weW),
    .regSrc_muxE(regSrc_muxE), .pc_srcD(pc_srcD),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_mem_stall(perf_mem_stall), .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;    // {stallF, stallD, stallE, stallM}
    logic       fld;
    logic       fle;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic fld, input logic fle,
                              input logic [1:0] fa, input logic [1:0] fb, input logic err);
    exp_t e;
    e.st = st; e.fld = fld; e.fle = fle; e.fa = fa; e.fb = fb; e.err = err;
    return e;
  endfunction

  // Monitor: the DUT presents a control vector every cycle; compare at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE, mem_err};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got st=%b flD=%b flE=%b fA=%b fB=%b err=%b, expected st=%b flD=%b flE=%b fA=%b fB=%b err=%b",
                 nm, a.st, a.fld, a.fle, a.fa, a.fb, a.err,
                 e.st, e.fld, e.fle, e.fa, e.fb, e.err);
      end
    end
  end

  task automatic clear_in();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeRegE = 0; writeRegM = 0; writeRegW = 0;
    Regfile_weE = 0; Regfile_weM = 0; Regfile_weW = 0;
    regSrc_muxE = 2'b00; pc_srcD = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // Inputs are already applied; queue the expectation for this cycle and advance.
  task automatic step(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] wr, input logic [1:0] src);
    Regfile_weE = 1; regSrc_muxE = src; writeRegE = wr;
  endtask

  initial begin
    rst = 0;
    clear_in();
    @(posedge clk);
    #1;

    // Reset held: everything low even with hazards on the inputs.
    dmem_req = 1; pc_srcD = 1; set_lu(5'd8, 2'b01); rsD = 8;
    rsE = 3; writeRegM = 3; Regfile_weM = 1;
    step("reset_held", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    clear_in();
    rst = 1;
    step("reset_idle", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

    // Load-use
    set_lu(5'd8, 2'b01); rsD = 8;
    step("lu_rs", mk(4'b1100, 0, 1, 2'b00, 2'b00, 0));
    clear_in();
    step("lu_one_cycle", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    set_lu(5'd0, 2'b01); rsD = 0;
    step("lu_r0", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    set_lu(5'd8, 2'b00); rsD = 8;
    step("lu_not_load", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    clear_in();
    set_lu(5'd9, 2'b01); rtD = 9; pc_srcD = 1;
    step("lu_wins_branch", mk(4'b1100, 0, 1, 2'b00, 2'b00, 0));
    clear_in();
    pc_srcD = 1;
    step("branch_flush", mk(4'b0000, 1, 0, 2'b00, 2'b00, 0));
    clear_in();

    // Three wait cycles, then ready
    dmem_req = 1;
    for (int i = 0; i < 3; i++) step("mem_wait3", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    dmem_ready = 1;
    step("mem_ready", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    clear_in();
    step("mem_back_run", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    dmem_req = 1; dmem_ready = 1;
    step("mem_zero_wait", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));

    // Freeze masks load-use and branch; lu applies once memory is ready
    dmem_ready = 0; set_lu(5'd7, 2'b01); rsD = 7; pc_srcD = 1;
    step("freeze_masks", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    dmem_ready = 1;
    step("lu_after_freeze", mk(4'b1100, 0, 1, 2'b00, 2'b00, 0));
    clear_in();

    // Forwarding
    writeRegM = 5; writeRegW = 5; Regfile_weM = 1; Regfile_weW = 1; rsE = 5; rtE = 5;
    step("fwd_mem_prio", mk(4'b0000, 0, 0, 2'b10, 2'b10, 0));
    Regfile_weM = 0;
    step("fwd_wb", mk(4'b0000, 0, 0, 2'b01, 2'b01, 0));
    Regfile_weM = 1; writeRegM = 0; writeRegW = 0; rtE = 0;
    step("fwd_r0", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    writeRegM = 4; writeRegW = 6; rsE = 6; rtE = 4;
    step("fwd_mixed", mk(4'b0000, 0, 0, 2'b01, 2'b10, 0));
    clear_in();

    // Watchdog: 16 frozen cycles, released on the 17th, flag latches afterwards
    dmem_req = 1;
    for (int i = 0; i < 16; i++) step("timeout_freeze", mk(4'b1111, 0, 0, 2'b00, 2'b00, 0));
    step("timeout_release", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    clear_in();
    step("mem_err_set", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));
    dmem_req = 1;
    step("err_next_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    dmem_ready = 1;
    step("err_next_ready", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));
    clear_in();
    step("err_sticky", mk(4'b0000, 0, 0, 2'b00, 2'b00, 1));

    // Asynchronous reset in the middle of MEM_WAIT (wait_cnt = 5)
    dmem_req = 1;
    for (int i = 0; i < 5; i++) step("pre_reset_wait", mk(4'b1111, 0, 0, 2'b00, 2'b00, 1));
    rst = 0;
    step("async_reset", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    rst = 1;
    dmem_req = 0;
    step("reset_to_run", mk(4'b0000, 0, 0, 2'b00, 2'b00, 0));
    pc_srcD = 1;
    step("post_reset_branch", mk(4'b0000, 1, 0, 2'b00, 2'b00, 0));
    clear_in();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
